// File: rtl/fram_arbiter_if.sv
// fram_arbiter_if: requester and RAM-side signal bundle for fram_arbiter.
//   slave  modport: arbiter view (requests/addresses/RAM data in; grants,
//                   rvalids, rdata, RAM address/strobe, boot_done out)
//   master modport: environment view (directions reversed)
//   Parameters: AW RAM address width, DW RAM data width.
interface fram_arbiter_if #(
   parameter int unsigned AW = 21,
   parameter int unsigned DW = 8
);
   logic          para_req;
   logic [AW-1:0] para_addr;
   logic          para_done;
   logic          para_gnt;
   logic          para_rvalid;
   logic          fe_req;
   logic [AW-1:0] fe_addr;
   logic          fe_gnt;
   logic          fe_rvalid;
   logic          de_req;
   logic [AW-1:0] de_addr;
   logic          de_gnt;
   logic          de_rvalid;
   logic [DW-1:0] rdata;
   logic [AW-1:0] fram_address;
   logic          fram_rd;
   logic [DW-1:0] fram_datain;
   logic          boot_done;

   modport slave (
      input  para_req, para_addr, para_done,
      input  fe_req, fe_addr, de_req, de_addr, fram_datain,
      output para_gnt, para_rvalid, fe_gnt, fe_rvalid, de_gnt, de_rvalid,
      output rdata, fram_address, fram_rd, boot_done
   );

   modport master (
      output para_req, para_addr, para_done,
      output fe_req, fe_addr, de_req, de_addr, fram_datain,
      input  para_gnt, para_rvalid, fe_gnt, fe_rvalid, de_gnt, de_rvalid,
      input  rdata, fram_address, fram_rd, boot_done
   );
endinterface

// File: rtl/fram_arbiter.sv
// fram_arbiter: three-way read arbiter/sequencer for the shared frame RAM.
//   Ports: clk (rising edge), reset (async, active-high),
//          bus (fram_arbiter_if.slave): para/fe/de req/addr/gnt/rvalid,
//          para_done, shared rdata, fram_address/fram_rd/fram_datain, boot_done.
//   Parameters: AW address width, DW data width, RD_LAT RAM read latency (1|2).
//   Option macro FRAM_ARB_RR_EN: fe/de round-robin; otherwise fixed para>fe>de.
//   Only the loader is served in BOOT; para_done moves the block to RUN.
module fram_arbiter #(
   parameter int unsigned AW     = 21,
   parameter int unsigned DW     = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   fram_arbiter_if.slave     bus
);

   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_PARA = 2'd1;
   localparam logic [1:0] OWN_FE   = 2'd2;
   localparam logic [1:0] OWN_DE   = 2'd3;

   logic [0:0]           state;
   logic                 gnt_para, gnt_fe, gnt_de, any_gnt;
   logic [AW-1:0]        sel_addr;
   logic [AW-1:0]        last_addr;
   logic [1:0]           tag0;
   // stage k (1..RD_LAT) lives in bits [2k-1:2k-2]; stage RD_LAT is on top
   logic [2*RD_LAT-1:0]  tag_pipe;
   logic [2*RD_LAT+1:0]  tag_ext;
   logic [1:0]           tag_last;
   logic [1:0]           own_q;
   logic [DW-1:0]        rdata_q;

`ifdef FRAM_ARB_RR_EN
   logic favour_de;

   // Grants are gated by reset so every gnt reads 0 while reset is held.
   always_comb begin
      gnt_para = 1'b0;
      gnt_fe   = 1'b0;
      gnt_de   = 1'b0;
      if (!reset) begin
         if (bus.para_req)
            gnt_para = 1'b1;
         else if (state == ST_RUN) begin
            if (bus.fe_req && (!bus.de_req || !favour_de))
               gnt_fe = 1'b1;
            else if (bus.de_req)
               gnt_de = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         favour_de <= 1'b0;
      else if (gnt_fe)
         favour_de <= 1'b1;
      else if (gnt_de)
         favour_de <= 1'b0;
   end
`else
   always_comb begin
      gnt_para = 1'b0;
      gnt_fe   = 1'b0;
      gnt_de   = 1'b0;
      if (!reset) begin
         if (bus.para_req)
            gnt_para = 1'b1;
         else if (state == ST_RUN) begin
            if (bus.fe_req)
               gnt_fe = 1'b1;
            else if (bus.de_req)
               gnt_de = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      any_gnt  = gnt_para | gnt_fe | gnt_de;
      sel_addr = bus.de_addr;
      tag0     = OWN_NONE;
      if (gnt_para) begin
         sel_addr = bus.para_addr;
         tag0     = OWN_PARA;
      end else if (gnt_fe) begin
         sel_addr = bus.fe_addr;
         tag0     = OWN_FE;
      end else if (gnt_de) begin
         tag0     = OWN_DE;
      end
   end

   // The top two bits of the extended vector are the oldest stage (RD_LAT),
   // the lower bits are the pipe shifted by one with the new tag inserted.
   assign tag_ext  = {tag_pipe, tag0};
   assign tag_last = tag_ext[2*RD_LAT+1 -: 2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_BOOT;
         last_addr <= '0;
         tag_pipe  <= '0;
         own_q     <= OWN_NONE;
         rdata_q   <= '0;
      end else begin
         if (state == ST_BOOT && bus.para_done)
            state <= ST_RUN;
         if (any_gnt)
            last_addr <= sel_addr;
         tag_pipe <= tag_ext[2*RD_LAT-1:0];
         own_q    <= tag_last;
         if (tag_last != OWN_NONE)
            rdata_q <= bus.fram_datain;
      end
   end

   assign bus.para_gnt     = gnt_para;
   assign bus.fe_gnt       = gnt_fe;
   assign bus.de_gnt       = gnt_de;
   assign bus.fram_rd      = any_gnt;
   assign bus.fram_address = any_gnt ? sel_addr : last_addr;
   assign bus.para_rvalid  = (own_q == OWN_PARA);
   assign bus.fe_rvalid    = (own_q == OWN_FE);
   assign bus.de_rvalid    = (own_q == OWN_DE);
   assign bus.rdata        = rdata_q;
   assign bus.boot_done    = (state == ST_RUN);

endmodule
